// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM read/write arbiter.
// Request fields are sized for the widest supported macro; instances use the low bits.
package sram_arb_pkg;

    localparam int NUM_REQ      = 2;
    localparam int REQ_ADDR_MAX = 16;
    localparam int REQ_DATA_MAX = 1024;
    localparam int REQ_MASK_MAX = 128;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                    write;
        logic [REQ_ADDR_MAX-1:0] addr;
        logic [REQ_MASK_MAX-1:0] wmask;
        logic [REQ_DATA_MAX-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_arb_resp_buf.sv
// Per-requester read tracking: one in-flight flag plus a registered response
// buffer with valid/ready handshake, loaded from the macro one cycle after the read.
module sram_arb_resp_buf #(
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rd_accept,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              resp_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              slot_free
);

    logic in_flight;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_flight  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            in_flight <= rd_accept;
            if (in_flight) begin
                resp_valid <= 1'b1;
                resp_rdata <= sram_rdata;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

    // A new read may issue only if its data will land in an empty buffer.
    assign slot_free = !in_flight && (!resp_valid || resp_ready);

endmodule

// File: rtl/sram_rw_arbiter.sv
// Round-robin arbiter sharing one masked single-port SRAM between two requesters.
// SRAM_ARB_INIT_CLEAR_EN adds a post-reset sweep writing INIT_VAL to every word.
//   state   | meaning
//   ST_INIT | clear sweep in progress, requests held off
//   ST_RUN  | arbitrating requests, one SRAM access per cycle
module sram_rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int                ADDR_W   = 9,
    parameter int                DATA_W   = 256,
    parameter int                MASK_W   = 32,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              r0_req_valid,
    output logic              r0_req_ready,
    input  logic              r0_req_write,
    input  logic [ADDR_W-1:0] r0_req_addr,
    input  logic [MASK_W-1:0] r0_req_wmask,
    input  logic [DATA_W-1:0] r0_req_wdata,
    output logic              r0_resp_valid,
    input  logic              r0_resp_ready,
    output logic [DATA_W-1:0] r0_resp_rdata,

    input  logic              r1_req_valid,
    output logic              r1_req_ready,
    input  logic              r1_req_write,
    input  logic [ADDR_W-1:0] r1_req_addr,
    input  logic [MASK_W-1:0] r1_req_wmask,
    input  logic [DATA_W-1:0] r1_req_wdata,
    output logic              r1_resp_valid,
    input  logic              r1_resp_ready,
    output logic [DATA_W-1:0] r1_resp_rdata,

    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,

    output logic              init_done
);

    arb_state_e           state;
    logic                 last_gnt;
    logic [ADDR_W-1:0]    sweep_addr;
    logic                 sweep_active;
    sram_req_t            req [NUM_REQ];
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   slot_free;
    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   gnt;
    logic                 gsel;
    logic                 unused_req;

    always_comb begin
        req[0] = '0;
        req[1] = '0;
        req[0].write               = r0_req_write;
        req[0].addr[ADDR_W-1:0]    = r0_req_addr;
        req[0].wmask[MASK_W-1:0]   = r0_req_wmask;
        req[0].wdata[DATA_W-1:0]   = r0_req_wdata;
        req[1].write               = r1_req_write;
        req[1].addr[ADDR_W-1:0]    = r1_req_addr;
        req[1].wmask[MASK_W-1:0]   = r1_req_wmask;
        req[1].wdata[DATA_W-1:0]   = r1_req_wdata;
    end

    assign unused_req = ^{req[0], req[1]};
    assign req_valid  = {r1_req_valid, r0_req_valid};

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && (req[i].write || slot_free[i]);
        end
    end

    // last_gnt = 1 means port 1 won the previous grant, so port 0 is favoured next.
    always_comb begin
        gnt = '0;
        if (rstn && state == ST_RUN) begin
            if (&elig) gnt = last_gnt ? 2'b01 : 2'b10;
            else       gnt = elig;
        end
    end

    assign gsel         = gnt[1];
    assign r0_req_ready = gnt[0];
    assign r1_req_ready = gnt[1];
    assign sweep_active = rstn && (state == ST_INIT);

    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (sweep_active) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = sweep_addr;
            sram_wmask = '1;
            sram_wdata = INIT_VAL;
        end else if (|gnt) begin
            sram_en    = 1'b1;
            sram_wmode = req[gsel].write;
            sram_addr  = req[gsel].addr[ADDR_W-1:0];
            sram_wmask = req[gsel].write ? req[gsel].wmask[MASK_W-1:0] : '0;
            sram_wdata = req[gsel].wdata[DATA_W-1:0];
        end
    end

`ifdef SRAM_ARB_INIT_CLEAR_EN
    logic init_done_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_INIT;
            sweep_addr  <= '0;
            init_done_q <= 1'b0;
            last_gnt    <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    sweep_addr <= sweep_addr + ADDR_W'(1);
                    if (&sweep_addr) begin
                        state       <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                default: begin
                    if (|gnt) last_gnt <= gnt[1];
                end
            endcase
        end
    end

    assign init_done = init_done_q;
`else
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_RUN;
            last_gnt <= 1'b1;
        end else if (|gnt) begin
            last_gnt <= gnt[1];
        end
    end

    assign sweep_addr = '0;
    assign init_done  = 1'b1;
`endif

    sram_arb_resp_buf #(.DATA_W(DATA_W)) u_resp0 (
        .clk        (clk),
        .rstn       (rstn),
        .rd_accept  (gnt[0] && !req[0].write),
        .sram_rdata (sram_rdata),
        .resp_ready (r0_resp_ready),
        .resp_valid (r0_resp_valid),
        .resp_rdata (r0_resp_rdata),
        .slot_free  (slot_free[0])
    );

    sram_arb_resp_buf #(.DATA_W(DATA_W)) u_resp1 (
        .clk        (clk),
        .rstn       (rstn),
        .rd_accept  (gnt[1] && !req[1].write),
        .sram_rdata (sram_rdata),
        .resp_ready (r1_resp_ready),
        .resp_valid (r1_resp_valid),
        .resp_rdata (r1_resp_rdata),
        .slot_free  (slot_free[1])
    );

endmodule

// File: doc/sram_rw_arbiter.md
Name: sram_rw_arbiter

Overview:
- Shares one single-port, masked, read-write SRAM macro (RW0-style port: en/wmode/addr/wmask/wdata, registered rdata one cycle after a read) between two requesters, e.g. a cache pipeline (port 0) and a refill/probe engine (port 1).
- Round-robin grant, one SRAM access per cycle, per-port registered read-response buffer with valid/ready backpressure, optional post-reset clear sweep.

Parameters:
- ADDR_W, 9, SRAM address width; depth = 2^ADDR_W.
- DATA_W, 256, SRAM word width.
- MASK_W, 32, write-mask width; DATA_W must be divisible by MASK_W.
- INIT_VAL, 0, DATA_W-bit pattern written by the clear sweep.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- rN_req_valid  in  1  request valid (N = 0,1; all rN_* ports are per requester).
- rN_req_ready  out  1  request accepted this cycle.
- rN_req_write  in  1  1 = write, 0 = read.
- rN_req_addr  in  ADDR_W  word address.
- rN_req_wmask  in  MASK_W  write lane enables.
- rN_req_wdata  in  DATA_W  write data.
- rN_resp_valid  out  1  read data held in response buffer.
- rN_resp_ready  in  1  requester consumes response.
- rN_resp_rdata  out  DATA_W  read data.
- sram_en  out  1  macro enable.
- sram_wmode  out  1  macro write mode.
- sram_addr  out  ADDR_W  macro address.
- sram_wmask  out  MASK_W  macro mask.
- sram_wdata  out  DATA_W  macro write data.
- sram_rdata  in  DATA_W  macro read data, valid the cycle after a read enable.
- init_done  out  1  sweep complete; arbiter accepting requests.

Behaviour:
- Reset values: all rN_req_ready, rN_resp_valid, sram_en, sram_wmode = 0; rN_resp_rdata = 0; round-robin pointer favours port 0; init_done per Optional Feature.
- States:
  - INIT (sweep only): entered from reset with macro defined.
  - RUN: entered after sweep completes, or directly from reset without macro.
- Eligibility: port N is eligible when req_valid and (req_write, or read slot free).
- Read slot free when there is no read in flight for N, and resp_valid is 0 or resp_ready is 1 this cycle.
- Grant (RUN only): if both ports are eligible, grant the port not granted last; if one is eligible, grant it. Pointer updates only on a grant.
- rN_req_ready is combinational and equals the grant. Only one port is ready per cycle.
- SRAM drive on grant cycle T:
  - sram_en = 1; sram_wmode = req_write; addr/wmask/wdata passed through.
  - sram_wmask is forced to 0 on reads.
  - With no grant, sram_en = 0 and other SRAM outputs are don't-care.
- Read latency:
  - In-flight flag set at edge ending T.
  - sram_rdata sampled at edge ending T+1 into the port's response buffer.
  - rN_resp_valid = 1 from cycle T+2 until the cycle after a resp_valid && resp_ready handshake.
  - Accept-to-response = 2 cycles.
- Throughput:
  - Back-to-back reads from one port are possible only if each response is consumed on its first valid cycle, i.e. every other cycle.
  - The other port may fill gap cycles.
- Writes never produce a response and are never blocked by a pending read response.
- Read after write, same address, write at T and read at T+1: the read returns the new data.
- Write at T+1 to the address being read at T: the response holds the pre-write data, since it is captured from the macro output at T+1.
- Response buffer contents are stable while resp_valid && !resp_ready.
- Asynchronous reset mid-operation: in-flight reads and buffered responses are discarded; pointer, state and counter return to reset values.

Optional Feature:
- Macro SRAM_ARB_INIT_CLEAR_EN.
- Defined:
  - After reset, state INIT writes INIT_VAL with all-ones mask to addresses 0..2^ADDR_W-1, one per cycle starting the first cycle after rstn deasserts.
  - Takes 2^ADDR_W cycles; all req_ready = 0 throughout.
  - init_done resets to 0 and rises the cycle after the last write; then RUN.
- Undefined: no sweep; init_done = 1 from reset; state is RUN immediately.

Decomposition:
- Shared package sram_arb_pkg:
  - state enum (INIT, RUN);
  - request struct typedef {write, addr, wmask, wdata};
  - requester count constant NUM_REQ = 2.
- One natural sub-module: sram_arb_resp_buf, per-port in-flight flag plus response register with valid/ready, instantiated twice.

Test Plan:
- Reset with macro, ADDR_W=4 → sram_en = 1, wmode = 1, wmask = all-ones for 16 consecutive cycles at addresses 0..15; init_done rises at cycle 17; then a read of address 5 returns INIT_VAL.
- r0 write addr 3 = 0xA5 (byte lane 0 only), then r0 read addr 3 → resp_valid 2 cycles after accept; rdata[7:0] = 0xA5; other lanes keep INIT_VAL.
- Both ports hold valid reads continuously with resp_ready = 1 → grants alternate 0,1,0,1; each port receives a response every 2 cycles.
- r1 read accepted, r1 resp_ready held 0 for 5 cycles → r1 not granted further reads, r1 writes still granted, rdata unchanged; grant resumes the cycle resp_ready = 1.
- Write addr 7 at T, r0 read addr 7 at T+1 → new data returned; read addr 9 at T, write addr 9 at T+1 → old data returned.
- Assert rstn low with a read in flight → resp_valid = 0 and sram_en = 0 immediately; no stale response appears after reset release.
